// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the operand sequencer: FSM state encoding, opcode type, data width.
package alu_seq_pkg;

    localparam int DATA_W = 16;

    typedef logic [2:0] alu_op_t;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        SETTLE,
        EXEC,
        WAIT_ALU,
        OUTPUT
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operand stream, register-file write port, ALU control and result stream of the sequencer.
interface alu_op_sequencer_if #(parameter int DW = alu_seq_pkg::DATA_W);

    logic [DW-1:0]        IN_DATA;
    alu_seq_pkg::alu_op_t IN_OP;
    logic                 IN_VALID;
    logic                 IN_READY;

    logic                 RF_WE;
    logic                 RF_W1;
    logic [DW-1:0]        RF_DIN;

    logic                 ALU_START;
    alu_seq_pkg::alu_op_t ALU_OP;
    logic                 ALU_DONE;
    logic [DW-1:0]        ALU_RESULT;

    logic [DW-1:0]        RES_DATA;
    logic                 RES_ERR;
    logic                 RES_VALID;
    logic                 RES_READY;

    logic                 BUSY;

    modport master (
        input  IN_DATA, IN_OP, IN_VALID, ALU_DONE, ALU_RESULT, RES_READY,
        output IN_READY, RF_WE, RF_W1, RF_DIN, ALU_START, ALU_OP,
               RES_DATA, RES_ERR, RES_VALID, BUSY
    );

    modport slave (
        output IN_DATA, IN_OP, IN_VALID, ALU_DONE, ALU_RESULT, RES_READY,
        input  IN_READY, RF_WE, RF_W1, RF_DIN, ALU_START, ALU_OP,
               RES_DATA, RES_ERR, RES_VALID, BUSY
    );

endinterface

// File: rtl/alu_op_sequencer_timeout_ctr.sv
// Clear/enable cycle counter; tc flags the last allowed wait cycle (count == TIMEOUT-1).
module seq_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads two operands into the register file, fires one ALU op, returns result or timeout error.
// Throughput one op per 5 cycles minimum; result held until RES_READY.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int DW      = DATA_W
) (
    input logic               CLK,
    input logic               RST,
    alu_op_sequencer_if.master bus
);

    seq_state_t state, next_state;
    logic       ctr_clr, ctr_en, to_tc;

    assign ctr_clr = (state == EXEC);
    assign ctr_en  = (state == WAIT_ALU);

    seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK (CLK),
        .RST (RST),
        .clr (ctr_clr),
        .en  (ctr_en),
        .tc  (to_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            LOAD_A:   if (bus.IN_VALID) next_state = LOAD_B;
            LOAD_B:   if (bus.IN_VALID) next_state = SETTLE;
            SETTLE:   next_state = EXEC;
            EXEC:     next_state = bus.ALU_DONE ? OUTPUT : WAIT_ALU;
            WAIT_ALU: if (bus.ALU_DONE || to_tc) next_state = OUTPUT;
            OUTPUT:   if (bus.RES_READY) next_state = LOAD_A;
            default:  next_state = LOAD_A;
        endcase
    end

    always_comb begin
        bus.IN_READY  = 1'b0;
        bus.RF_WE     = 1'b0;
        bus.RF_W1     = 1'b0;
        bus.RES_VALID = 1'b0;
        bus.BUSY      = (state != LOAD_A);
        unique case (state)
            LOAD_A: begin
                bus.IN_READY = 1'b1;
                bus.RF_WE    = bus.IN_VALID;
            end
            LOAD_B: begin
                bus.IN_READY = 1'b1;
                bus.RF_WE    = bus.IN_VALID;
                bus.RF_W1    = 1'b1;
            end
            OUTPUT:  bus.RES_VALID = 1'b1;
            default: ;
        endcase
    end

    assign bus.RF_DIN = bus.IN_DATA;

    // The cycle after SETTLE is EXEC, so registering the SETTLE decode gives a pulse aligned to EXEC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.ALU_START <= 1'b0;
            bus.ALU_OP    <= '0;
            bus.RES_DATA  <= {DW{1'b0}};
            bus.RES_ERR   <= 1'b0;
        end else begin
            bus.ALU_START <= (state == SETTLE);
            if (state == LOAD_B && bus.IN_VALID) begin
                bus.ALU_OP <= bus.IN_OP;
            end
            if ((state == EXEC || state == WAIT_ALU) && bus.ALU_DONE) begin
                bus.RES_DATA <= bus.ALU_RESULT;
                bus.RES_ERR  <= 1'b0;
            end else if (state == WAIT_ALU && to_tc) begin
                bus.RES_DATA <= {DW{1'b0}};
                bus.RES_ERR  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a register-file and ALU model on the slave side.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int TO = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    alu_op_sequencer_if #(.DW(16)) bus ();

    alu_op_sequencer #(.TIMEOUT(TO), .DW(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } res_t;

    res_t exp_q[$];
    int   asserts = 0;
    int   fails   = 0;
    int   cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input alu_op_t op);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU model: delay counts WAIT_ALU cycles after EXEC; 0 answers during EXEC itself.
    logic [15:0] rf [2];
    int  alu_delay = 0;
    bit  alu_never = 0;
    bit  pend = 0;
    int  k = 0;
    bit  done_now;

    always @(negedge CLK) begin
        if (RST) begin
            pend = 0;
        end else if (bus.ALU_START) begin
            pend = !alu_never;
            k = 0;
        end else if (pend) begin
            k++;
        end
        done_now = pend && (k == alu_delay);
        bus.ALU_DONE = done_now;
        bus.ALU_RESULT = done_now ? alu_fn(rf[0], rf[1], bus.ALU_OP) : 16'hDEAD;
        if (done_now) pend = 0;
    end

    int   start_cnt = 0, start_cyc = 0, valid_cyc = 0, res_seen = 0, wr_cnt = 0;
    logic w1_log[$];
    bit   prev_valid = 0;
    res_t ex;

    always @(negedge CLK) begin
        #2;
        if (bus.RF_WE) begin
            wr_cnt++;
            w1_log.push_back(bus.RF_W1);
            rf[bus.RF_W1] = bus.RF_DIN;
        end
        if (bus.ALU_START) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (bus.RES_VALID && !prev_valid) valid_cyc = cyc;
        prev_valid = bus.RES_VALID;
        if (bus.RES_VALID && bus.RES_READY) begin
            res_seen++;
            asserts++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got err=%0b data=%h, required no result", bus.RES_ERR, bus.RES_DATA);
            end else begin
                ex = exp_q.pop_front();
                if ({bus.RES_ERR, bus.RES_DATA} !== {ex.err, ex.data}) begin
                    fails++;
                    $display("FAIL sb_result: got err=%0b data=%h, required err=%0b data=%h",
                             bus.RES_ERR, bus.RES_DATA, ex.err, ex.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_word(input logic [15:0] d, input alu_op_t op, output int e_cyc);
        bit ok = 0;
        bus.IN_DATA  = d;
        bus.IN_OP    = op;
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (bus.IN_READY) ok = 1;
            @(negedge CLK);
        end
        e_cyc = cyc;
        if (!ok) begin
            asserts++;
            fails++;
            $display("FAIL send_timeout: got IN_READY=0 for 200 cycles, required 1");
        end
    endtask

    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input alu_op_t op,
                           input bit push, input logic err, input logic [15:0] d, output int e_cyc);
        int dummy;
        send_word(a, op, dummy);
        send_word(b, op, e_cyc);
        if (push) exp_q.push_back(res_t'{err, d});
    endtask

    task automatic wait_res(input int target);
        int i = 0;
        while (res_seen < target && i < 300) begin
            @(negedge CLK);
            i++;
        end
        if (res_seen < target) begin
            asserts++;
            fails++;
            $display("FAIL wait_result: got %0d results, required %0d", res_seen, target);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN_DATA = '0; bus.IN_OP = '0; bus.RES_READY = 1'b0;
        repeat (3) @(negedge CLK);
        asserts++; if (bus.IN_READY !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", bus.IN_READY); end
        asserts++; if (bus.RES_VALID !== 1'b0) begin fails++; $display("FAIL rst_res_valid: got %b, required 0", bus.RES_VALID); end
        asserts++; if (bus.RES_DATA !== 16'h0) begin fails++; $display("FAIL rst_res_data: got %h, required 0", bus.RES_DATA); end
        asserts++; if (bus.RES_ERR !== 1'b0) begin fails++; $display("FAIL rst_res_err: got %b, required 0", bus.RES_ERR); end
        asserts++; if (bus.ALU_START !== 1'b0) begin fails++; $display("FAIL rst_alu_start: got %b, required 0", bus.ALU_START); end
        asserts++; if (bus.ALU_OP !== 3'd0) begin fails++; $display("FAIL rst_alu_op: got %0d, required 0", bus.ALU_OP); end
        asserts++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, required 0", bus.BUSY); end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        int e, tgt;
        alu_delay = 0; alu_never = 0; bus.RES_READY = 1'b1;
        start_cnt = 0; wr_cnt = 0; w1_log.delete();
        tgt = res_seen + 1;
        send_op(16'h0003, 16'h0004, 3'd1, 1, 1'b0, 16'h0007, e);
        bus.IN_VALID = 1'b0;
        wait_res(tgt);
        asserts++;
        if (w1_log.size() != 2 || w1_log[0] !== 1'b0 || w1_log[1] !== 1'b1) begin
            fails++; $display("FAIL basic_rf_writes: got %0d writes, required 2 (W1=0 then 1)", w1_log.size());
        end
        asserts++; if (start_cnt != 1) begin fails++; $display("FAIL basic_start_len: got %0d cycles, required 1", start_cnt); end
        asserts++; if (start_cyc != e + 1) begin fails++; $display("FAIL basic_start_cyc: got %0d, required %0d", start_cyc, e + 1); end
        asserts++; if (valid_cyc != e + 2) begin fails++; $display("FAIL basic_latency: got %0d, required %0d", valid_cyc, e + 2); end
    endtask

    task automatic test_delay();
        int e, i;
        bit op_bad = 0;
        alu_delay = 5; bus.RES_READY = 1'b1;
        send_op(16'h0055, 16'h00FF, 3'd3, 1, 1'b0, 16'h00AA, e);
        bus.IN_VALID = 1'b0;
        i = 0;
        while (!bus.RES_VALID && i < 100) begin
            if (bus.ALU_OP !== 3'd3) op_bad = 1;
            @(negedge CLK);
            i++;
        end
        if (bus.ALU_OP !== 3'd3) op_bad = 1;
        @(negedge CLK);
        asserts++; if (op_bad) begin fails++; $display("FAIL delay_op_stable: got unstable ALU_OP, required 3"); end
        asserts++; if (valid_cyc != e + 7) begin fails++; $display("FAIL delay_latency: got %0d, required %0d", valid_cyc, e + 7); end
    endtask

    task automatic test_timeout();
        int e, tgt;
        bus.RES_READY = 1'b1;
        alu_never = 1;
        tgt = res_seen + 1;
        send_op(16'h0011, 16'h0022, 3'd1, 1, 1'b1, 16'h0000, e);
        bus.IN_VALID = 1'b0;
        wait_res(tgt);
        asserts++; if (valid_cyc != e + TO + 2) begin fails++; $display("FAIL timeout_bound: got %0d, required %0d", valid_cyc, e + TO + 2); end
        alu_never = 0; alu_delay = TO;
        tgt = res_seen + 1;
        send_op(16'h0011, 16'h0022, 3'd1, 1, 1'b0, 16'h0033, e);
        bus.IN_VALID = 1'b0;
        wait_res(tgt);
        asserts++; if (valid_cyc != e + TO + 2) begin fails++; $display("FAIL done_at_terminal: got %0d, required %0d", valid_cyc, e + TO + 2); end
    endtask

    task automatic test_hold();
        int e, wc, i, tgt;
        bit v_bad = 0, d_bad = 0, r_bad = 0;
        alu_delay = 0; bus.RES_READY = 1'b0;
        send_op(16'h1234, 16'h0101, 3'd2, 1, 1'b0, 16'h1133, e);
        bus.IN_VALID = 1'b0;
        i = 0;
        while (!bus.RES_VALID && i < 50) begin @(negedge CLK); i++; end
        bus.IN_VALID = 1'b1; bus.IN_DATA = 16'hBEEF;
        #3 wc = wr_cnt;
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            if (bus.RES_VALID !== 1'b1) v_bad = 1;
            if (bus.RES_DATA !== 16'h1133) d_bad = 1;
            if (bus.IN_READY !== 1'b0) r_bad = 1;
        end
        #3;
        asserts++; if (v_bad) begin fails++; $display("FAIL hold_valid: got RES_VALID drop, required 1"); end
        asserts++; if (d_bad) begin fails++; $display("FAIL hold_data: got %h, required 1133", bus.RES_DATA); end
        asserts++; if (r_bad) begin fails++; $display("FAIL hold_in_ready: got 1, required 0"); end
        asserts++; if (wr_cnt != wc) begin fails++; $display("FAIL hold_rf_writes: got %0d, required %0d", wr_cnt, wc); end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        tgt = res_seen + 1;
        bus.RES_READY = 1'b1;
        wait_res(tgt);
    endtask

    task automatic test_reset_mid();
        int e, tgt;
        alu_never = 1; bus.RES_READY = 1'b1;
        send_op(16'h0007, 16'h0008, 3'd1, 0, 1'b0, 16'h0000, e);
        bus.IN_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        asserts++; if (bus.IN_READY !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b, required 1", bus.IN_READY); end
        asserts++; if (bus.RES_VALID !== 1'b0) begin fails++; $display("FAIL midrst_res_valid: got %b, required 0", bus.RES_VALID); end
        asserts++; if (bus.BUSY !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b, required 0", bus.BUSY); end
        RST = 1'b0;
        alu_never = 0; alu_delay = 2;
        tgt = res_seen + 1;
        send_op(16'h0100, 16'h0023, 3'd2, 1, 1'b0, 16'h00DD, e);
        bus.IN_VALID = 1'b0;
        wait_res(tgt);
        asserts++; if (valid_cyc != e + 4) begin fails++; $display("FAIL midrst_recover: got %0d, required %0d", valid_cyc, e + 4); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [4] = '{16'h0010, 16'hFFFF, 16'h1234, 16'h8000};
        logic [15:0] bv [4] = '{16'h0020, 16'h0001, 16'h4321, 16'h0FF0};
        alu_op_t     ov [4] = '{3'd1, 3'd1, 3'd2, 3'd3};
        int ec [4];
        int tgt;
        alu_delay = 0; bus.RES_READY = 1'b1;
        tgt = res_seen + 4;
        for (int i = 0; i < 4; i++)
            send_op(av[i], bv[i], ov[i], 1, 1'b0, alu_fn(av[i], bv[i], ov[i]), ec[i]);
        bus.IN_VALID = 1'b0;
        wait_res(tgt);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (ec[i+1] - ec[i] != 5) begin
                fails++; $display("FAIL b2b_period%0d: got %0d cycles, required 5", i, ec[i+1] - ec[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(negedge CLK);
        asserts++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequences the two-entry operand register file and the ALU behind it. Accepts two 16-bit operands over a valid/ready stream, writes them into register 0 and register 1, waits for the register file's registered read outputs to settle, and issues one ALU operation. It then returns the ALU result, or a timeout error, over a second valid/ready stream. It sits between the input front-end and the register/ALU datapath and is the only writer of the register file.

## Interface
- TIMEOUT, default 16: maximum cycles spent waiting for ALU_DONE after ALU_START; range 1..255.
- DW, default 16: data width; must match the register file.
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  DW  operand word.
- IN_OP  input  3  ALU opcode; sampled together with the second operand.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  sequencer can accept an operand.
- RF_WE  output  1  register-file write enable (combinational).
- RF_W1  output  1  register-file write index: 0 for the first operand, 1 for the second.
- RF_DIN  output  DW  register-file write data; equal to IN_DATA.
- ALU_START  output  1  one-cycle start pulse (registered).
- ALU_OP  output  3  opcode held stable from EXEC until the next operation (registered).
- ALU_DONE  input  1  ALU result valid.
- ALU_RESULT  input  DW  ALU result.
- RES_DATA  output  DW  result (registered).
- RES_ERR  output  1  set when the result was produced by timeout (registered).
- RES_VALID  output  1  result valid.
- RES_READY  input  1  consumer accepts the result.
- BUSY  output  1  high in every state except LOAD_A.

## Operation
- States: LOAD_A, LOAD_B, SETTLE, EXEC, WAIT_ALU, OUTPUT.
- LOAD_A:
  - IN_READY=1.
  - On IN_VALID&&IN_READY: RF_WE=1 and RF_W1=0 in the same cycle; go to LOAD_B.
- LOAD_B:
  - IN_READY=1.
  - On handshake: RF_WE=1, RF_W1=1, and IN_OP is captured into ALU_OP; go to SETTLE.
- SETTLE:
  - Lasts exactly one cycle.
  - Covers the extra registered-read cycle between a register-file write and valid Dout_1/Dout_2.
- EXEC:
  - Lasts exactly one cycle; ALU_START=1.
  - The timeout counter is cleared to 0.
  - ALU_DONE is sampled at the end of EXEC. If it is high, capture the result and go to OUTPUT; otherwise go to WAIT_ALU.
- WAIT_ALU:
  - The counter increments each cycle.
  - If ALU_DONE is high: RES_DATA<=ALU_RESULT, RES_ERR<=0, go to OUTPUT.
  - Else, if the counter reaches TIMEOUT-1: RES_DATA<=0, RES_ERR<=1, go to OUTPUT.
  - ALU_DONE has priority over timeout in the same cycle.
- OUTPUT:
  - RES_VALID=1; RES_DATA and RES_ERR are held stable.
  - On RES_READY: go to LOAD_A.
- RF_WE is high only in LOAD_A or LOAD_B during a handshake. IN_READY is low in all other states.
- ALU_DONE is ignored outside EXEC and WAIT_ALU.
- Reset (also mid-operation):
  - Next state LOAD_A.
  - IN_READY=1 after reset; RES_VALID=0, RES_DATA=0, RES_ERR=0, ALU_START=0, ALU_OP=0, counter=0, BUSY=0.
  - Register-file contents are not cleared; the next operation overwrites both entries.

## Timing
- Second operand accepted at edge e:
  - RF[1] is written at e.
  - Operand outputs are valid after e+1.
  - ALU_START is high in the cycle between e+1 and e+2.
- Minimum latency, with ALU_DONE high during EXEC: RES_VALID rises after edge e+2.
- Timeout: RES_VALID with RES_ERR rises no later than TIMEOUT+1 cycles after ALU_START.
- Throughput:
  - At most one operand per cycle in LOAD_A/LOAD_B.
  - Minimum 5 cycles per operation with RES_READY held high.
- RES_VALID never drops without RES_READY; no combinational path from RES_READY to RES_VALID.

## Structure
- Shared package alu_seq_pkg:
  - State enum seq_state_t.
  - Opcode typedef alu_op_t (3 bits).
  - Constant DATA_W=16.
- One sub-module, seq_timeout_ctr: clear/enable counter with a terminal-count output, parameterised by TIMEOUT.
- The FSM, output registers and combinational RF drive live in the top module.

## Test plan
- Operands 16'h0003, 16'h0004 with IN_OP=3'd1; ALU model asserts DONE during EXEC with 16'h0007 → RF_WE pulses with W1=0 then 1; ALU_START exactly one cycle; RES_DATA=16'h0007, RES_ERR=0, RES_VALID after e+2.
- ALU model delays DONE by 5 cycles, result 16'h00AA → RES_DATA=16'h00AA, RES_ERR=0; ALU_OP stable throughout.
- ALU never asserts DONE, TIMEOUT=16 → RES_ERR=1 and RES_DATA=0 exactly at the timeout bound; DONE on the terminal cycle instead yields RES_ERR=0.
- RES_READY held low for 10 cycles → RES_VALID and RES_DATA stable, IN_READY=0, no RF writes despite IN_VALID=1.
- RST asserted in WAIT_ALU → next cycle: LOAD_A, IN_READY=1, RES_VALID=0, BUSY=0; a new operation then completes correctly.
- Back-to-back operations with continuous IN_VALID and RES_READY → 5-cycle period; each result matches its own operand pair.
